multdiv_seq: RTL and testbench
==============================

Name: multdiv_seq

Overview:
- Iterative signed 32-bit multiply/divide unit; the responder to the execute-stage control's mul/div request.
- Accepts a one-cycle start pulse (ctrl_MULT or ctrl_DIV) with its operands and computes over a fixed iteration count.
- Returns result, exception flag and a one-cycle ready pulse. Execute-stage control muxes the result into the X-stage result, and uses the ready pulse as its stall release and the exception as its overflow.

Parameters:
- WIDTH, 32, operand/result width in bits.
- ITERS, WIDTH, iteration cycles per operation; fixed equal to WIDTH, not independently overridable.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- ctrl_MULT  in  1  start-multiply pulse; operands sampled this cycle.
- ctrl_DIV  in  1  start-divide pulse; operands sampled this cycle.
- data_operandA  in  WIDTH  multiplicand / dividend, two's complement.
- data_operandB  in  WIDTH  multiplier / divisor, two's complement.
- data_result  out  WIDTH  low WIDTH bits of product, or quotient.
- data_exception  out  1  overflow / divide-by-zero flag for the held result.
- data_resultRDY  out  1  one-cycle pulse: result and exception valid.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, internal registers cleared. Any in-flight operation is discarded and no ready pulse is produced.
- States:
  - IDLE: waits for a start pulse.
  - MUL: radix-2 Booth, one iteration per cycle.
  - DIV: magnitude restoring division, one iteration per cycle.
  - DONE: one cycle; writes outputs and pulses ready.
- Start: ctrl_MULT=1 or ctrl_DIV=1 at edge T latches operands and op type, clears the counter, and enters MUL or DIV.
  - Both start inputs high: MULT wins.
  - Operand inputs are ignored outside start cycles.
- Latency: ITERS iteration cycles, then DONE. data_resultRDY=1 exactly in the cycle after edge T+ITERS+1, i.e. 33 cycles after the start pulse for WIDTH=32. Latency is identical for every operand value, including divide-by-zero.
- Start while busy (MUL, DIV or DONE): abort the current operation and restart with the new operands. The aborted operation produces no ready pulse.
- Multiply:
  - 2*WIDTH-bit signed product computed.
  - data_result = product[WIDTH-1:0].
  - data_exception = 1 iff product[2*WIDTH-1:WIDTH-1] is not all-equal (result does not fit in signed WIDTH bits).
- Divide:
  - Quotient truncates toward zero; quotient sign = signA XOR signB. Remainder is discarded.
  - Divisor 0: data_result=0, data_exception=1.
  - A=0x80000000, B=0xFFFFFFFF: data_result=0x80000000, data_exception=1.
  - All other cases: data_exception=0.
- Output hold: data_result and data_exception update only in DONE and hold until the next DONE or reset. data_resultRDY is low in every other cycle.
- DONE -> IDLE unless a start is present in the DONE cycle, which is then taken as a new start.

Decomposition:
- Shared package: WIDTH default, state encoding (IDLE/MUL/DIV/DONE), and the constant INT_MIN = 32'h80000000.
- One natural sub-module, multdiv_counter: a ceil(log2(ITERS+1))-bit counter with sync clear, enable and terminal-count flag.
- Adder/subtractor datapath stays in the top module.

Test Plan:
- A=7, B=-6 (0xFFFFFFFA), ctrl_MULT pulse -> at cycle 33: data_resultRDY=1 for one cycle, data_result=0xFFFFFFD6, data_exception=0; ready low at cycles 32 and 34.
- A=0x00010000, B=0x00010000, MULT -> data_result=0x00000000, data_exception=1. Also A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF, data_exception=0.
- Divide, signed cases:
  - A=-7, B=2 -> 0xFFFFFFFD, data_exception=0.
  - A=100, B=-7 -> 0xFFFFFFF2 (-14).
  - A=0x80000000, B=0xFFFFFFFF -> 0x80000000, data_exception=1.
- A=5, B=0, ctrl_DIV -> at cycle 33: data_result=0, data_exception=1. Result and flag then held unchanged for 10 idle cycles.
- Restart, multiply: MULT 3*4, then at cycle 10 MULT 5*6 -> single ready pulse 33 cycles after the second start, data_result=30.
- Restart, simultaneous starts: ctrl_MULT and ctrl_DIV both high with A=6, B=3 -> data_result=18 (MULT wins).
- reset=0 at cycle 15 of a divide -> all outputs 0 immediately (asynchronous). No ready pulse for 40 cycles after release; a fresh DIV 9/3 -> 3.

Source files
------------

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared width default, FSM encoding and constants for the multiply/divide unit.
package multdiv_pkg;
    localparam int DEF_WIDTH = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
endpackage

// File: rtl/multdiv_counter.sv
// multdiv_counter: iteration counter with sync clear, enable and a last-iteration flag.
module multdiv_counter #(
    parameter int ITERS = 32,
    parameter int CW = $clog2(ITERS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : en ? cnt_q + CW'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign cnt = cnt_q;
    assign tc  = cnt_q == CW'(ITERS - 1);
endmodule

// File: rtl/multdiv_seq.sv
// multdiv_seq: iterative signed multiply (radix-2 Booth) / divide (restoring, on magnitudes).
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    localparam int ITERS = WIDTH;
    localparam int CW = $clog2(ITERS + 1);
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state_q, state_d;
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d, m_q, m_d, res_q, res_d;
    logic qm1_q, qm1_d, neg_q, neg_d, dz_q, dz_d, ovf_q, ovf_d, div_q, div_d;
    logic exc_q, exc_d, rdy_q, rdy_d;
    logic start, last, cnt_en;
    logic [CW-1:0] cnt;
    logic [WIDTH:0] m_ext, booth_sum, shifted, diff;
    logic [WIDTH-1:0] mag_a, mag_b, quot;
    logic [2*WIDTH-1:0] prod;
    logic mul_ovf;

    assign start  = ctrl_MULT | ctrl_DIV;
    assign cnt_en = (state_q == MUL || state_q == DIV) && !start;

    multdiv_counter #(.ITERS(ITERS), .CW(CW)) u_cnt (
        .clk  (clock),
        .rst_n(reset),
        .clr  (start),
        .en   (cnt_en),
        .cnt  (cnt),
        .tc   (last)
    );

    always_comb begin
        mag_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        mag_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        m_ext     = {m_q[WIDTH-1], m_q};
        booth_sum = {lo_q[0], qm1_q} == 2'b01 ? hi_q + m_ext :
                    {lo_q[0], qm1_q} == 2'b10 ? hi_q - m_ext : hi_q;
        shifted   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        diff      = shifted - {1'b0, m_q};
        prod      = {hi_q[WIDTH-1:0], lo_q};
        // Product fits in signed WIDTH bits only if its top WIDTH+1 bits are all equal.
        mul_ovf   = !(&prod[2*WIDTH-1:WIDTH-1] || ~|prod[2*WIDTH-1:WIDTH-1]);
        quot      = neg_q ? -lo_q : lo_q;
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        qm1_d   = qm1_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        div_d   = div_q;
        res_d   = res_q;
        exc_d   = exc_q;
        rdy_d   = 1'b0;
        if (start) begin
            state_d = ctrl_MULT ? MUL : DIV;
            div_d   = !ctrl_MULT;
            hi_d    = '0;
            qm1_d   = 1'b0;
            lo_d    = ctrl_MULT ? data_operandB : mag_a;
            m_d     = ctrl_MULT ? data_operandA : mag_b;
            neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_d    = data_operandB == '0;
            ovf_d   = data_operandA == MIN_V && data_operandB == '1;
        end else if (state_q == MUL) begin
            hi_d    = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            lo_d    = {booth_sum[0], lo_q[WIDTH-1:1]};
            qm1_d   = lo_q[0];
            state_d = last ? DONE : MUL;
        end else if (state_q == DIV) begin
            hi_d    = diff[WIDTH] ? shifted : diff;
            lo_d    = {lo_q[WIDTH-2:0], !diff[WIDTH]};
            state_d = last ? DONE : DIV;
        end else if (state_q == DONE) begin
            res_d   = div_q ? (dz_q ? '0 : quot) : prod[WIDTH-1:0];
            exc_d   = div_q ? dz_q || ovf_q : mul_ovf;
            rdy_d   = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            div_q   <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
            qm1_q   <= qm1_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            div_q   <= div_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            rdy_q   <= rdy_d;
        end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: directed vectors for multdiv_seq, checking latency, results, flags, restart and reset.
module tb_multdiv_seq;
    import multdiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    int          n_tests = 0;
    int          n_fail = 0;

    multdiv_seq dut (
        .clock         (clock),
        .reset         (reset),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drives a start pulse through one rising edge, then scrambles the operands.
    task automatic start_op(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT = mul;
        ctrl_DIV = div;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic run_op(input string tag, input logic mul, input logic div,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc);
        int at = 0;
        int pulses = 0;
        logic [31:0] res = '0;
        logic exc = 1'b0;
        start_op(mul, div, a, b);
        for (int k = 1; k <= 35; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                pulses++;
                if (at == 0) begin
                    at = k;
                    res = data_result;
                    exc = data_exception;
                end
            end
        end
        chk({tag, "_cycle"}, at, 33);
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_res"}, res, exp_res);
        chk({tag, "_exc"}, {31'b0, exc}, {31'b0, exp_exc});
    endtask

    initial begin
        int pulses;
        #12;
        chk("rst_res", data_result, 32'h0);
        chk("rst_exc", {31'b0, data_exception}, 32'h0);
        chk("rst_rdy", {31'b0, data_resultRDY}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        run_op("mul_7x-6", 1, 0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 0);
        run_op("mul_2^16sq", 1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1);
        run_op("mul_max", 1, 0, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 0);
        run_op("mul_min_x-1", 1, 0, INT_MIN, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("mul_-5x-5", 1, 0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd25, 0);
        run_op("div_-7/2", 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_op("div_100/-7", 0, 1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 0);
        run_op("div_min/-1", 0, 1, INT_MIN, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("div_5/0", 0, 1, 32'd5, 32'd0, 32'h0, 1);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
            chk("hold_res", data_result, 32'h0);
            chk("hold_exc", {31'b0, data_exception}, 32'h1);
        end
        chk("hold_pulses", pulses, 0);
        start_op(1, 0, 32'd3, 32'd4);
        pulses = 0;
        for (int k = 1; k < 10; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        chk("restart_early", pulses, 0);
        run_op("restart_5x6", 1, 0, 32'd5, 32'd6, 32'd30, 0);
        run_op("both_6x3", 1, 1, 32'd6, 32'd3, 32'd18, 0);
        start_op(0, 1, 32'd1000, 32'd7);
        for (int k = 1; k < 15; k++) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_res", data_result, 32'h0);
        chk("arst_exc", {31'b0, data_exception}, 32'h0);
        chk("arst_rdy", {31'b0, data_resultRDY}, 32'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        chk("arst_no_rdy", pulses, 0);
        run_op("div_9/3", 0, 1, 32'd9, 32'd3, 32'd3, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
